// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset/bring-up sequencer for the pipelined MIPS system.
// Releases NUM_DOMAINS reset domains one at a time. Each domain must acknowledge
// before the next one is released. A missing ack trips a sticky timeout error.
// Software can re-run the sequence from RUN or ERROR. A saturating counter
// measures time spent in RUN.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int CYC_W       = 32,
  localparam int DOM_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   soft_reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_ack,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic                   timeout_err,
  output logic [DOM_W-1:0]       err_domain,
  output logic [2:0]             seq_state,
  output logic [CYC_W-1:0]       cycle_count
);

  // The one shared counter must reach the longest of the three intervals it times.
  localparam int CNT_MAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_MAX_B = (CNT_MAX_A > ACK_TIMEOUT) ? CNT_MAX_A : ACK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_B > 1) ? CNT_MAX_B : 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [DOM_W-1:0] LAST_STAGE = DOM_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_GAP      = 3'd2,
    S_RUN      = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [DOM_W-1:0]       r_stage;
  logic [NUM_DOMAINS-1:0] r_domainRst;
  logic                   r_allReady;
  logic                   r_timeoutErr;
  logic [DOM_W-1:0]       r_errDomain;
  logic [CYC_W-1:0]       r_cycleCount;

  state_t                 w_stateNext;
  logic [CNT_W-1:0]       w_cntNext;
  logic [DOM_W-1:0]       w_stageNext;
  logic [NUM_DOMAINS-1:0] w_domainRstNext;
  logic                   w_allReadyNext;
  logic                   w_timeoutErrNext;
  logic [DOM_W-1:0]       w_errDomainNext;
  logic [CYC_W-1:0]       w_cycleCountNext;

  logic [NUM_DOMAINS-1:0] w_stageMask;
  logic [NUM_DOMAINS-1:0] w_nextStageMask;
  logic                   w_ackCur;
  logic                   w_restart;

  // Select the ack of the domain being waited on. Acks from other domains are ignored.
  always_comb begin
    w_stageMask     = NUM_DOMAINS'(1) << r_stage;
    w_nextStageMask = NUM_DOMAINS'(1) << (r_stage + DOM_W'(1));
    w_ackCur        = |(domain_ack & w_stageMask);
    w_restart       = soft_reset_req && ((r_state == S_RUN) || (r_state == S_ERROR));
  end

  // Compute the next state and the next value of every registered output.
  // A soft reset and an illegal encoding both restart the sequence from HOLD.
  always_comb begin
    w_stateNext      = r_state;
    w_cntNext        = r_cnt;
    w_stageNext      = r_stage;
    w_domainRstNext  = r_domainRst;
    w_allReadyNext   = r_allReady;
    w_timeoutErrNext = r_timeoutErr;
    w_errDomainNext  = r_errDomain;
    w_cycleCountNext = r_cycleCount;

    case (r_state)
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_domainRstNext = r_domainRst & ~w_stageMask;
          w_cntNext       = '0;
          w_stateNext     = S_WAIT_ACK;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_ACK: begin
        if (w_ackCur) begin
          if (r_stage == LAST_STAGE) begin
            w_stateNext    = S_RUN;
            w_allReadyNext = 1'b1;
          end else begin
            w_stateNext = S_GAP;
            w_cntNext   = '0;
          end
        end else if ((ACK_TIMEOUT != 0) && (r_cnt == TOUT_LAST)) begin
          w_stateNext      = S_ERROR;
          w_timeoutErrNext = 1'b1;
          w_errDomainNext  = r_stage;
          w_domainRstNext  = '1;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_stageNext     = r_stage + DOM_W'(1);
          w_domainRstNext = r_domainRst & ~w_nextStageMask;
          w_cntNext       = '0;
          w_stateNext     = S_WAIT_ACK;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (r_cycleCount != '1) begin
          w_cycleCountNext = r_cycleCount + CYC_W'(1);
        end
      end
      S_ERROR: begin
        w_domainRstNext = '1;
        w_allReadyNext  = 1'b0;
      end
      default: begin
        w_stateNext = S_HOLD;
      end
    endcase

    if (w_restart || (r_state > S_ERROR)) begin
      w_stateNext      = S_HOLD;
      w_cntNext        = '0;
      w_stageNext      = '0;
      w_domainRstNext  = '1;
      w_allReadyNext   = 1'b0;
      w_timeoutErrNext = 1'b0;
      w_errDomainNext  = '0;
      w_cycleCountNext = '0;
    end
  end

  // Register the state and all outputs. Global reset overrides everything.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state      <= S_HOLD;
      r_cnt        <= '0;
      r_stage      <= '0;
      r_domainRst  <= '1;
      r_allReady   <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_errDomain  <= '0;
      r_cycleCount <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_cnt        <= w_cntNext;
      r_stage      <= w_stageNext;
      r_domainRst  <= w_domainRstNext;
      r_allReady   <= w_allReadyNext;
      r_timeoutErr <= w_timeoutErrNext;
      r_errDomain  <= w_errDomainNext;
      r_cycleCount <= w_cycleCountNext;
    end
  end

  assign domain_rst  = r_domainRst;
  assign all_ready   = r_allReady;
  assign timeout_err = r_timeoutErr;
  assign err_domain  = r_errDomain;
  assign seq_state   = r_state;
  assign cycle_count = r_cycleCount;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer.
// A timeline model derives release, ack and timeout edges from per-domain ack delays.
// Drivers push the expected outputs after each edge into queues.
// Monitors pop those expectations and compare them against the DUT.
module tb_reset_sequencer;

  localparam int NUM_SEQ = 24;

  typedef struct packed {
    logic [3:0]  rst;
    logic        ready;
    logic        terr;
    logic [1:0]  errDom;
    logic [2:0]  st;
    logic [31:0] cc;
  } exp_t;

  typedef struct packed {
    logic [3:0][31:0] rel;
    logic [3:0][31:0] ackE;
    int               errIdx;
    int               errE;
  } sched_t;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        reset, softReq;
  logic [3:0]  ack;
  logic [3:0]  domRst;
  logic        allReady, timeoutErr;
  logic [1:0]  errDomain;
  logic [2:0]  seqState;
  logic [31:0] cycleCount;

  logic        reset2, softReq2, ack2;
  logic        domRst2, allReady2, timeoutErr2, errDomain2;
  logic [2:0]  seqState2;
  logic [3:0]  cycleCount2;

  int nChecks = 0;
  int nFail   = 0;

  exp_t expQ[$];
  exp_t expQ2[$];

  reset_sequencer dut (
    .sysclk(sysclk), .reset(reset), .soft_reset_req(softReq), .domain_ack(ack),
    .domain_rst(domRst), .all_ready(allReady), .timeout_err(timeoutErr),
    .err_domain(errDomain), .seq_state(seqState), .cycle_count(cycleCount)
  );

  reset_sequencer #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .ACK_TIMEOUT(0), .CYC_W(4)
  ) dutAux (
    .sysclk(sysclk), .reset(reset2), .soft_reset_req(softReq2), .domain_ack(ack2),
    .domain_rst(domRst2), .all_ready(allReady2), .timeout_err(timeoutErr2),
    .err_domain(errDomain2), .seq_state(seqState2), .cycle_count(cycleCount2)
  );

  // One comparison: count it, and report it when it fails.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [3:0] a);
    reset   = r;
    softReq = s;
    ack     = a;
  endtask

  task automatic applyStimulusAux(input logic r, input logic s, input logic a);
    reset2   = r;
    softReq2 = s;
    ack2     = a;
  endtask

  // Timeline of one bring-up, counted in edges from the restart edge (edge 0).
  // Domain i is released at rel[i] and acked at ackE[i].
  // A delay of at least the timeout value ends the sequence in an error at errE.
  function automatic sched_t schedule(input int nDom, input int hold, input int gap,
                                      input int tout, input logic [3:0][31:0] dly);
    sched_t s;
    int t;
    s = '0;
    s.errIdx = -1;
    t = hold;
    for (int i = 0; i < nDom; i++) begin
      s.rel[i] = 32'(t);
      if (tout != 0 && int'(dly[i]) >= tout) begin
        s.errIdx = i;
        s.errE   = t + tout;
        break;
      end
      s.ackE[i] = 32'(t + int'(dly[i]) + 1);
      t = int'(s.ackE[i]) + gap;
    end
    return s;
  endfunction

  // Expected outputs after edge k of the timeline.
  function automatic exp_t modelAt(input int k, input int nDom, input int cycW, input sched_t s);
    exp_t e;
    int last;
    longint lim, diff;
    e = '0;
    e.rst = 4'b1111;
    if (s.errIdx >= 0 && k >= s.errE) begin
      e.terr   = 1'b1;
      e.errDom = 2'(s.errIdx);
      e.st     = 3'd4;
      return e;
    end
    last = (s.errIdx >= 0) ? s.errIdx : nDom - 1;
    for (int i = 0; i <= last; i++) begin
      if (k >= int'(s.rel[i])) begin
        e.rst[i] = 1'b0;
        e.st     = 3'd1;
        if (i != s.errIdx && k >= int'(s.ackE[i])) e.st = (i == nDom - 1) ? 3'd3 : 3'd2;
      end
    end
    if (s.errIdx < 0 && k >= int'(s.ackE[nDom-1])) begin
      e.ready = 1'b1;
      lim  = (longint'(1) << cycW) - 1;
      diff = longint'(k) - longint'(s.ackE[nDom-1]);
      e.cc = 32'((diff > lim) ? lim : diff);
    end
    return e;
  endfunction

  // Ack inputs presented for edge k+1.
  // The awaited domain's ack rises once its delay has elapsed.
  // All other ack bits are random, so the DUT must ignore them.
  function automatic logic [3:0] ackDrive(input int k, input int nDom, input sched_t s,
                                          input logic [3:0][31:0] dly);
    logic [3:0] a;
    int endW;
    a = 4'($urandom);
    for (int i = 0; i < nDom; i++) begin
      if (s.errIdx < 0 || i <= s.errIdx) begin
        endW = (i == s.errIdx) ? s.errE : int'(s.ackE[i]);
        if (k >= int'(s.rel[i]) && k < endW) a[i] = (k >= int'(s.rel[i]) + int'(dly[i]));
      end
    end
    return a;
  endfunction

  // Per-domain ack delays.
  // The first three sequences are fixed: prompt acks, domain 2 silent, and a domain 1 ack on the last cycle.
  function automatic logic [3:0][31:0] pickDelays(input int seqIdx);
    logic [3:0][31:0] dly;
    int r;
    for (int i = 0; i < 4; i++) begin
      r = int'($urandom % 16);
      if (r == 0)      dly[i] = 32'd63;
      else if (r == 1) dly[i] = 32'(64 + ($urandom % 8));
      else             dly[i] = 32'($urandom % 6);
    end
    if (seqIdx == 0) dly = '0;
    if (seqIdx == 1) begin dly = '0; dly[2] = 32'd200; end
    if (seqIdx == 2) begin dly = '0; dly[1] = 32'd63; end
    return dly;
  endfunction

  // Main driver for the default configuration.
  // It runs many bring-ups and ends each one with a global or soft reset.
  // It also injects ignored soft resets and occasional global resets while in GAP.
  task automatic runMain();
    sched_t s;
    exp_t e;
    logic [3:0][31:0] dly;
    int k = 0;
    int seqCount = 0;
    int runLen = 0;
    int budget = 0;
    bit restart = 1'b1;
    bit done = 1'b0;
    bit endSeq;
    logic rNext, sNext;
    s = '0;
    dly = '0;
    applyStimulus(1'b1, 1'b0, 4'b0000);
    while (!done && budget < 30000) begin
      @(posedge sysclk);
      #1;
      budget++;
      if (restart) begin
        k = 0;
        dly = pickDelays(seqCount);
        runLen = int'($urandom_range(2, 12));
        seqCount++;
        s = schedule(4, 10, 2, 64, dly);
      end else begin
        k++;
      end
      e = modelAt(k, 4, 32, s);
      expQ.push_back(e);
      rNext = 1'b0;
      sNext = 1'b0;
      endSeq = 1'b0;
      if (e.st == 3'd2 && ($urandom % 6) == 0) sNext = 1'b1;
      if (e.st == 3'd2 && ($urandom % 40) == 0) rNext = 1'b1;
      if (e.st == 3'd3 && k - int'(s.ackE[3]) >= runLen) endSeq = 1'b1;
      if (e.st == 3'd4 && k - s.errE >= 100) endSeq = 1'b1;
      if (endSeq) begin
        if (seqCount >= NUM_SEQ) done = 1'b1;
        else if (($urandom % 2) == 0) rNext = 1'b1;
        else sNext = 1'b1;
      end
      restart = rNext || (sNext && (e.st == 3'd3 || e.st == 3'd4));
      applyStimulus(rNext, sNext, ackDrive(k, 4, s, dly));
    end
    checkOutput("main_completed", 64'(done), 64'd1);
  endtask

  // Driver for the single-domain configuration with no timeout.
  // The ack stays low for 500 cycles and must not cause an error.
  // Once acked, the 4-bit cycle counter must saturate.
  task automatic runAux();
    sched_t s;
    logic [3:0][31:0] dly;
    logic [3:0] a;
    dly = '0;
    dly[0] = 32'd500;
    s = schedule(1, 1, 1, 0, dly);
    applyStimulusAux(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 540; k++) begin
      @(posedge sysclk);
      #1;
      expQ2.push_back(modelAt(k, 1, 4, s));
      a = ackDrive(k, 1, s, dly);
      applyStimulusAux(1'b0, 1'b0, a[0]);
    end
  endtask

  // Monitor for the default DUT: compares every output after each edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("domain_rst", 64'(domRst), 64'(e.rst));
        checkOutput("all_ready", 64'(allReady), 64'(e.ready));
        checkOutput("timeout_err", 64'(timeoutErr), 64'(e.terr));
        checkOutput("err_domain", 64'(errDomain), 64'(e.errDom));
        checkOutput("seq_state", 64'(seqState), 64'(e.st));
        checkOutput("cycle_count", 64'(cycleCount), 64'(e.cc));
      end
    end
  end

  // Monitor for the single-domain DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (expQ2.size() != 0) begin
        e = expQ2.pop_front();
        checkOutput("aux_domain_rst", 64'(domRst2), 64'(e.rst[0]));
        checkOutput("aux_all_ready", 64'(allReady2), 64'(e.ready));
        checkOutput("aux_timeout_err", 64'(timeoutErr2), 64'(e.terr));
        checkOutput("aux_err_domain", 64'(errDomain2), 64'(e.errDom[0]));
        checkOutput("aux_seq_state", 64'(seqState2), 64'(e.st));
        checkOutput("aux_cycle_count", 64'(cycleCount2), 64'(e.cc[3:0]));
      end
    end
  end

  // Run both drivers, drain the scoreboards, then report.
  initial begin
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulusAux(1'b1, 1'b0, 1'b0);
    $display("[TB] starting reset_sequencer bench");
    fork
      runMain();
      runAux();
    join
    repeat (2) @(negedge sysclk);
    #1;
    checkOutput("scoreboard_drained", 64'(expQ.size() + expQ2.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
